// File: rtl/sound_bus_responder.sv
// Sound-CPU bus responder: decodes the sound CPU bus onto ROM, internal RAM,
// the GA20 and YM chips, and a main-CPU mailbox with a reply register.
module sound_bus_responder (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [1:0]  mem_be,
  input  logic [19:0] mem_addr,
  input  logic [15:0] mem_dout,
  output logic [15:0] mem_din,
  output logic [16:0] rom_addr,
  input  logic [15:0] rom_data,
  output logic        ym_cs,
  output logic        ym_wr,
  output logic        ym_a0,
  output logic [7:0]  ym_dout,
  input  logic [7:0]  ym_din,
  input  logic        ym_irq_n,
  output logic        ga20_cs,
  output logic        ga20_wr,
  output logic [4:0]  ga20_addr,
  output logic [7:0]  ga20_dout,
  input  logic [7:0]  ga20_din,
  input  logic        latch_wr,
  input  logic [7:0]  latch_data,
  output logic [7:0]  reply_data,
  output logic        reply_stb,
  output logic        intp0,
  output logic        intp1,
  output logic        mailbox_state
);

  // Mailbox handshake: latch_wr (main CPU) fills the mailbox, a sound-CPU
  // write to the ack address empties it; latch_wr wins a same-cycle clash.
  typedef enum logic {MB_EMPTY = 1'b0, MB_FULL = 1'b1} mb_state_t;

  mb_state_t   state, state_nx;
  logic [7:0]  latch;
  logic [15:0] ram [8192];
  logic [15:0] rd_data;
  logic        rom_pending;

  logic sel_rom, sel_ram, sel_ga20, sel_ym, sel_latch, sel_reply;
  logic rd_ok, wr_ok, ack_wr;

  assign sel_rom   = (mem_addr[19:17] == 3'b000);
  assign sel_ram   = (mem_addr[19:14] == 6'b101000);
  assign sel_ga20  = (mem_addr[19:6]  == 14'h2A00);
  assign sel_ym    = (mem_addr[19:2]  == 18'h2A010);
  assign sel_latch = (mem_addr[19:1]  == 19'h54022);
  assign sel_reply = (mem_addr[19:1]  == 19'h54023);

  // Reset masks the bus so an access in flight produces no side effects.
  assign rd_ok  = mem_rd & ~reset;
  assign wr_ok  = mem_wr & ~reset;
  assign ack_wr = wr_ok & sel_latch;

  assign rom_addr  = mem_addr[16:0];
  assign ga20_cs   = (rd_ok | wr_ok) & sel_ga20;
  assign ga20_wr   = ga20_cs & mem_wr;
  assign ga20_addr = mem_addr[5:1];
  assign ga20_dout = mem_dout[7:0];
  assign ym_cs     = (rd_ok | wr_ok) & sel_ym;
  assign ym_wr     = ym_cs & mem_wr;
  assign ym_a0     = mem_addr[1];
  assign ym_dout   = mem_dout[7:0];

  // RAM has no reset so its contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (wr_ok && sel_ram) begin
      if (mem_be[0]) ram[mem_addr[13:1]][7:0]  <= mem_dout[7:0];
      if (mem_be[1]) ram[mem_addr[13:1]][15:8] <= mem_dout[15:8];
    end
  end

  // ROM data arrives one clk after the address, so during that clk it is
  // forwarded straight through and then captured to hold until the next read.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data     <= 16'hFFFF;
      rom_pending <= 1'b0;
    end else if (mem_rd) begin
      rom_pending <= sel_rom;
      if (sel_ram)        rd_data <= ram[mem_addr[13:1]];
      else if (sel_ga20)  rd_data <= {8'h00, ga20_din};
      else if (sel_ym)    rd_data <= {8'h00, ym_din};
      else if (sel_latch) rd_data <= {8'h00, latch};
      else if (!sel_rom)  rd_data <= 16'hFFFF;
    end else if (rom_pending) begin
      rom_pending <= 1'b0;
      rd_data     <= rom_data;
    end
  end

  assign mem_din = rom_pending ? rom_data : rd_data;

  always_ff @(posedge clk) begin
    if (reset) state <= MB_EMPTY;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      MB_EMPTY: if (latch_wr) state_nx = MB_FULL;
      MB_FULL:  if (!latch_wr && ack_wr) state_nx = MB_EMPTY;
      default:  state_nx = MB_EMPTY;
    endcase
  end

  assign intp1         = (state == MB_EMPTY);
  assign mailbox_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      latch      <= 8'h00;
      reply_data <= 8'h00;
      reply_stb  <= 1'b0;
      intp0      <= 1'b1;
    end else begin
      if (latch_wr) latch <= latch_data;
      reply_stb <= wr_ok & sel_reply & mem_be[0];
      if (wr_ok && sel_reply && mem_be[0]) reply_data <= mem_dout[7:0];
      intp0 <= ym_irq_n;
    end
  end

endmodule

// File: tb/tb_sound_bus_responder.sv
// Bench for sound_bus_responder: directed scenarios plus random bus traffic
// compared against an address-map level model of the sound subsystem.
module tb_sound_bus_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_rd, mem_wr;
  logic [1:0]  mem_be;
  logic [19:0] mem_addr;
  logic [15:0] mem_dout, mem_din;
  logic [16:0] rom_addr;
  logic [15:0] rom_data;
  logic        ym_cs, ym_wr, ym_a0, ym_irq_n;
  logic [7:0]  ym_dout, ym_din;
  logic        ga20_cs, ga20_wr;
  logic [4:0]  ga20_addr;
  logic [7:0]  ga20_dout, ga20_din;
  logic        latch_wr;
  logic [7:0]  latch_data, reply_data;
  logic        reply_stb, intp0, intp1, mailbox_state;

  sound_bus_responder dut (
    .clk(clk), .reset(reset), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_din(mem_din),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .ym_cs(ym_cs), .ym_wr(ym_wr), .ym_a0(ym_a0), .ym_dout(ym_dout), .ym_din(ym_din),
    .ym_irq_n(ym_irq_n),
    .ga20_cs(ga20_cs), .ga20_wr(ga20_wr), .ga20_addr(ga20_addr), .ga20_dout(ga20_dout),
    .ga20_din(ga20_din),
    .latch_wr(latch_wr), .latch_data(latch_data), .reply_data(reply_data),
    .reply_stb(reply_stb), .intp0(intp0), .intp1(intp1), .mailbox_state(mailbox_state)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rom_fn(input logic [16:0] a);
    return {a[7:0] ^ 8'h3C, a[16:9]};
  endfunction

  // Synchronous external ROM: data one clk after the address.
  always @(posedge clk) rom_data <= rom_fn(rom_addr);

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference model state
  logic [7:0]  m_ram [16384];
  logic        m_full, m_stb, m_intp0;
  logic [7:0]  m_latch, m_reply;
  logic [15:0] exp_din;
  logic [15:0] exp_q[$];
  bit          primed = 0;

  function automatic logic [15:0] model_read(input logic [19:0] a, input logic [7:0] yd,
                                             input logic [7:0] gd);
    if (a <= 20'h1FFFF) return rom_fn(a[16:0]);
    if (a inside {[20'hA0000:20'hA3FFF]}) return {m_ram[{a[13:1], 1'b1}], m_ram[{a[13:1], 1'b0}]};
    if (a inside {[20'hA8000:20'hA803F]}) return {8'h00, gd};
    if (a inside {[20'hA8040:20'hA8043]}) return {8'h00, yd};
    if (a inside {[20'hA8044:20'hA8045]}) return {8'h00, m_latch};
    return 16'hFFFF;
  endfunction

  // One bus clock: check results of the previous edge, drive this cycle's
  // inputs, check the combinational strobes, then advance the model.
  task automatic do_cycle(input logic rd, input logic wr, input logic [1:0] be,
                          input logic [19:0] addr, input logic [15:0] dout,
                          input logic lwr, input logic [7:0] ldata,
                          input logic [7:0] yd, input logic rst);
    logic acc, in_ga20, in_ym;
    logic [7:0] gd;
    logic irq;
    @(negedge clk);
    if (primed) begin
      if (exp_q.size() > 0) exp_din = exp_q.pop_front();
      check_eq("mem_din", mem_din, exp_din);
      check_eq("intp1", intp1, !m_full);
      check_eq("mailbox_state", mailbox_state, m_full);
      check_eq("intp0", intp0, m_intp0);
      check_eq("reply_stb", reply_stb, m_stb);
      check_eq("reply_data", reply_data, m_reply);
    end
    gd  = 8'($urandom);
    irq = 1'($urandom);
    reset = rst; mem_rd = rd; mem_wr = wr; mem_be = be; mem_addr = addr; mem_dout = dout;
    latch_wr = lwr; latch_data = ldata; ym_din = yd; ga20_din = gd; ym_irq_n = irq;
    #1;
    acc     = !rst && (rd || wr);
    in_ga20 = addr inside {[20'hA8000:20'hA803F]};
    in_ym   = addr inside {[20'hA8040:20'hA8043]};
    if (primed) begin
      check_eq("rom_addr", rom_addr, addr & 20'h1FFFF);
      check_eq("ga20_cs", ga20_cs, acc && in_ga20);
      check_eq("ga20_wr", ga20_wr, acc && in_ga20 && wr);
      check_eq("ym_cs", ym_cs, acc && in_ym);
      check_eq("ym_wr", ym_wr, acc && in_ym && wr);
      if (acc && in_ga20) begin
        check_eq("ga20_addr", ga20_addr, (addr - 20'hA8000) / 2);
        check_eq("ga20_dout", ga20_dout, dout & 16'h00FF);
      end
      if (acc && in_ym) begin
        check_eq("ym_a0", ym_a0, (addr - 20'hA8040) >= 2);
        check_eq("ym_dout", ym_dout, dout & 16'h00FF);
      end
    end
    if (rst) begin
      m_full = 0; m_latch = 8'h00; m_reply = 8'h00; m_stb = 0; m_intp0 = 1;
      exp_din = 16'hFFFF; exp_q.delete();
    end else begin
      m_intp0 = irq;
      m_stb   = 0;
      if (rd) exp_q.push_back(model_read(addr, yd, gd));
      if (wr && addr inside {[20'hA0000:20'hA3FFF]}) begin
        if (be[0]) m_ram[{addr[13:1], 1'b0}] = dout[7:0];
        if (be[1]) m_ram[{addr[13:1], 1'b1}] = dout[15:8];
      end
      if (wr && addr inside {[20'hA8044:20'hA8045]}) m_full = 0;
      if (wr && addr inside {[20'hA8046:20'hA8047]} && be[0]) begin
        m_reply = dout[7:0];
        m_stb   = 1;
      end
      if (lwr) begin
        m_full  = 1;
        m_latch = ldata;
      end
    end
    primed = 1;
  endtask

  task automatic idle();
    do_cycle(0, 0, 2'b00, 20'h00000, 16'h0000, 0, 8'h00, 8'h00, 0);
  endtask

  task automatic bus_wr(input logic [19:0] a, input logic [15:0] d, input logic [1:0] be);
    do_cycle(0, 1, be, a, d, 0, 8'h00, 8'h00, 0);
  endtask

  task automatic bus_rd(input logic [19:0] a);
    do_cycle(1, 0, 2'b11, a, 16'h0000, 0, 8'h00, 8'($urandom), 0);
  endtask

  function automatic logic [19:0] ram_addr();
    int idx;
    idx = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 255) : $urandom_range(8128, 8191);
    return 20'hA0000 + 20'(idx * 2) + 20'($urandom_range(0, 1));
  endfunction

  logic [19:0] unm [6];

  initial begin
    unm = '{20'h50000, 20'h20000, 20'hA4000, 20'hA8048, 20'hA7FFE, 20'hFFFFF};
    // reset
    repeat (3) do_cycle(0, 0, 2'b00, 20'h0, 16'h0, 0, 8'h00, 8'h00, 1);
    idle();
    check_eq("rst_mem_din", mem_din, 16'hFFFF);
    check_eq("rst_intp1", intp1, 1'b1);

    // give every RAM word the random traffic can reach a known value
    for (int i = 0; i < 256; i++) bus_wr(20'hA0000 + 20'(i * 2), 16'($urandom), 2'b11);
    for (int i = 8128; i < 8192; i++) bus_wr(20'hA0000 + 20'(i * 2), 16'($urandom), 2'b11);

    // byte-lane merge
    bus_wr(20'hA0010, 16'h1234, 2'b11);
    bus_wr(20'hA0011, 16'hAB00, 2'b10);
    bus_rd(20'hA0010);
    idle();
    check_eq("ram_merge", mem_din, 16'hAB34);

    // mailbox fill, read, ack
    do_cycle(0, 0, 2'b00, 20'h0, 16'h0, 1, 8'h5A, 8'h00, 0);
    idle();
    check_eq("mb_full_intp1", intp1, 1'b0);
    bus_rd(20'hA8044);
    idle();
    check_eq("mb_read", mem_din, 16'h005A);
    check_eq("mb_read_intp1", intp1, 1'b0);
    bus_wr(20'hA8044, 16'h0000, 2'b11);
    idle();
    check_eq("mb_ack_intp1", intp1, 1'b1);

    // latch_wr beats a same-cycle ack
    do_cycle(0, 1, 2'b11, 20'hA8044, 16'h0000, 1, 8'h11, 8'h00, 0);
    idle();
    check_eq("mb_clash_intp1", intp1, 1'b0);
    bus_rd(20'hA8044);
    idle();
    check_eq("mb_clash_data", mem_din, 16'h0011);

    // reply register
    bus_wr(20'hA8046, 16'h00C3, 2'b01);
    idle();
    check_eq("reply_pulse", reply_stb, 1'b1);
    check_eq("reply_val", reply_data, 8'hC3);
    idle();
    check_eq("reply_single", reply_stb, 1'b0);
    bus_wr(20'hA8046, 16'h00FF, 2'b10);
    idle();
    check_eq("reply_be_off", reply_stb, 1'b0);
    check_eq("reply_keep", reply_data, 8'hC3);

    // unmapped, ROM write, YM status read
    bus_rd(20'h50000);
    idle();
    check_eq("unmapped_rd", mem_din, 16'hFFFF);
    bus_wr(20'h00100, 16'hBEEF, 2'b11);
    bus_rd(20'h00100);
    bus_rd(20'hA0100);
    do_cycle(1, 0, 2'b11, 20'hA8042, 16'h0, 0, 8'h00, 8'h80, 0);
    check_eq("ym_cs_pulse", ym_cs, 1'b1);
    check_eq("ym_a0_hi", ym_a0, 1'b1);
    idle();
    check_eq("ym_status", mem_din, 16'h0080);
    idle();
    check_eq("ym_cs_done", ym_cs, 1'b0);

    // reset while FULL, with an access in flight
    do_cycle(0, 0, 2'b00, 20'h0, 16'h0, 1, 8'h77, 8'h00, 0);
    bus_wr(20'hA0020, 16'h5678, 2'b11);
    do_cycle(1, 0, 2'b11, 20'hA8040, 16'h0, 1, 8'h99, 8'h00, 1);
    check_eq("rst_ym_cs", ym_cs, 1'b0);
    idle();
    check_eq("rst_full_intp1", intp1, 1'b1);
    check_eq("rst_state", mailbox_state, 1'b0);
    check_eq("rst_din", mem_din, 16'hFFFF);
    bus_rd(20'hA0020);
    idle();
    check_eq("ram_survives_rst", mem_din, 16'h5678);

    // random back-to-back traffic
    for (int n = 0; n < 1500; n++) begin
      logic [19:0] a;
      logic        lwr, rst;
      logic [7:0]  ld, yd;
      logic [15:0] d;
      logic [1:0]  be;
      lwr = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 199) == 0);
      ld  = 8'($urandom);
      yd  = 8'($urandom);
      d   = 16'($urandom);
      be  = 2'($urandom);
      case ($urandom_range(0, 11))
        0:  do_cycle(0, 1, be, ram_addr(), d, lwr, ld, yd, rst);
        1:  do_cycle(1, 0, be, ram_addr(), d, lwr, ld, yd, rst);
        2:  do_cycle(1, 0, be, 20'($urandom_range(0, 20'h1FFFF)), d, lwr, ld, yd, rst);
        3:  do_cycle(0, 1, be, 20'($urandom_range(0, 20'h1FFFF)), d, lwr, ld, yd, rst);
        4:  do_cycle(1, 0, be, unm[$urandom_range(0, 5)], d, lwr, ld, yd, rst);
        5:  do_cycle(0, 1, be, unm[$urandom_range(0, 5)], d, lwr, ld, yd, rst);
        6: begin
          a = 20'hA8000 + 20'($urandom_range(0, 63));
          if ($urandom_range(0, 1) == 0) do_cycle(1, 0, be, a, d, lwr, ld, yd, rst);
          else                           do_cycle(0, 1, be, a, d, lwr, ld, yd, rst);
        end
        7: begin
          a = 20'hA8040 + 20'($urandom_range(0, 3));
          if ($urandom_range(0, 1) == 0) do_cycle(1, 0, be, a, d, lwr, ld, yd, rst);
          else                           do_cycle(0, 1, be, a, d, lwr, ld, yd, rst);
        end
        8:  do_cycle(1, 0, be, 20'hA8044 + 20'($urandom_range(0, 1)), d, lwr, ld, yd, rst);
        9:  do_cycle(0, 1, be, 20'hA8044 + 20'($urandom_range(0, 1)), d, lwr, ld, yd, rst);
        10: do_cycle(0, 1, be, 20'hA8046 + 20'($urandom_range(0, 1)), d, lwr, ld, yd, rst);
        default: do_cycle(0, 0, be, 20'($urandom), d, lwr, ld, yd, rst);
      endcase
    end
    idle();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sound_bus_responder.md
SOUND_BUS_RESPONDER -- requirements
Module: sound_bus_responder

Interface
REQ-001 clk  in  1  system clock; all state changes on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 mem_rd / mem_wr  in  1 each  sound-CPU bus strobes, one-clk pulses; never both high together.
REQ-004 mem_be  in  2  byte enables, bit0 = D[7:0], bit1 = D[15:8].
REQ-005 mem_addr  in  20  byte address; mem_dout  in  16  CPU write data; mem_din  out  16  read data to CPU.
REQ-006 rom_addr  out  17  = mem_addr[16:0] combinational; rom_data  in  16  external sync ROM data, valid 1 clk after rom_addr.
REQ-007 ym_cs, ym_wr, ym_a0  out  1 each; ym_dout  out  8; ym_din  in  8 (status); ym_irq_n  in  1.
REQ-008 ga20_cs, ga20_wr  out  1 each; ga20_addr  out  5 (word reg); ga20_dout  out  8; ga20_din  in  8.
REQ-009 latch_wr  in  1, latch_data  in  8  main-CPU mailbox write; reply_data  out  8; reply_stb  out  1.
REQ-010 intp0, intp1  out  1 each  sound-CPU interrupt pins, active low.

Function
REQ-011 Address map SHALL be: 00000-1FFFF ROM; A0000-A3FFF RAM; A8000-A803F GA20; A8040 YM addr; A8042 YM data/status; A8044 latch read / ack write; A8046 reply write; all else unmapped.
REQ-012 RAM SHALL be 8K x 16 internal, word index mem_addr[13:1], byte writes gated by mem_be.
REQ-013 Read latency SHALL be exactly 1 clk: decode registered on mem_rd, mem_din valid next clk and held until the next mem_rd.
REQ-014 Read data: ROM -> rom_data; RAM -> word; GA20/YM/latch -> {8'h00, byte}; unmapped -> 16'hFFFF.
REQ-015 Writes to ROM or unmapped space SHALL be ignored, no side effects.
REQ-016 GA20: ga20_cs 1-clk pulse on any access in range; ga20_wr = mem_wr; ga20_addr = mem_addr[5:1]; ga20_dout = mem_dout[7:0].
REQ-017 YM: ym_cs 1-clk pulse on access to A8040/A8042; ym_a0 = mem_addr[1]; ym_wr = mem_wr; ym_dout = mem_dout[7:0]; read returns ym_din.
REQ-018 intp0 SHALL equal ym_irq_n registered by one clk.
REQ-019 Mailbox FSM states: EMPTY, FULL. EMPTY->FULL on latch_wr (latch := latch_data); FULL->FULL on latch_wr (data overwritten); FULL->EMPTY on CPU write to A8044 (data ignored).
REQ-020 intp1 SHALL be 0 in FULL, 1 in EMPTY, registered (changes 1 clk after the causing event).
REQ-021 latch_wr and ack write in same clk: latch_wr wins, state FULL, new data stored.
REQ-022 Reading A8044 SHALL return latch without changing state.
REQ-023 CPU write to A8046 with mem_be[0]=1: reply_data := mem_dout[7:0], reply_stb high exactly 1 clk after; be[0]=0 -> no effect.
REQ-024 Back-to-back accesses on consecutive clks SHALL each complete independently; no internal busy state.

Reset
REQ-025 During reset: mem_din=16'hFFFF, mailbox EMPTY, latch=8'h00, reply_data=8'h00, reply_stb=0, intp0=1, intp1=1, ym_cs=ga20_cs=ym_wr=ga20_wr=0.
REQ-026 Reset asserted mid-access SHALL abort it: no strobe emitted after reset, pending FULL cleared, RAM contents unaffected.

Verification
REQ-027 Write A0010 = 16'h1234 be=11, write A0011 be=10 data 16'hAB00, read A0010 -> mem_din=16'hAB34 one clk after mem_rd.
REQ-028 latch_wr data 8'h5A -> intp1=0 next clk; read A8044 -> 16'h005A, intp1 stays 0; write A8044 -> intp1=1 next clk.
REQ-029 latch_wr 8'h11 and ack write same clk -> FULL, intp1=0, latch read 16'h0011.
REQ-030 Write A8046 data 16'h00C3 be=01 -> reply_data=8'hC3, reply_stb single 1-clk pulse; be=10 -> no pulse.
REQ-031 Read 50000 -> 16'hFFFF; write 00100 -> ROM and RAM unchanged; read A8042 with ym_din=8'h80 -> 16'h0080, ym_cs pulse, ym_a0=1.
REQ-032 Set FULL, assert reset 1 clk -> intp1=1, mailbox EMPTY, mem_din=16'hFFFF; RAM word written before reset reads back unchanged.
